// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_e      : controller state (RUN / MEM_WAIT)
//   REG_ZERO     : architectural zero register index (never a real dependency)
//   load_use_hit : true when a load in EX writes a register read by the instruction in ID
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, never wraps.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset (clears the count)
//   inc_i  : count enable for this cycle
//   cnt_o  : current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Each cycle it decides
// whether PC, IF/ID, ID/EX and EX/MEM load, hold, or take a bubble/flush.
// Priority: memory wait > load-use > taken-branch flush.
//   clk_i, rst_i                 : clock; asynchronous active-low reset
//   ID_RSAddr_i, ID_RTAddr_i     : source registers of the instruction in ID
//   EX_MemRead_i, EX_RTAddr_i    : load in EX and its destination register
//   Branch_taken_i               : branch/jump resolved taken in ID
//   MEM_req_i, MEM_ack_i         : data-memory request / completion
//   PCWrite_o .. MEM_WB_Bubble_o : pipeline register enables / bubble / flush selects (Mealy)
//   err_timeout_o                : sticky, memory wait reached TIMEOUT_CYC cycles
//   stall_cnt_o, flush_cnt_o     : saturating counts of stall / flush cycles
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RSAddr_i,
  input  logic [4:0]       ID_RTAddr_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_RTAddr_i,
  input  logic             Branch_taken_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ack_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Write_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Bubble_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              err_q;
  logic              mem_stall;
  logic              load_use;

  always_comb begin
    state_d         = state_q;
    PCWrite_o       = 1'b1;
    IF_ID_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Write_o   = 1'b1;
    ID_EX_Bubble_o  = 1'b0;
    EX_MEM_Write_o  = 1'b1;
    MEM_WB_Bubble_o = 1'b0;
    mem_stall       = MEM_req_i && !MEM_ack_i;
    load_use        = load_use_hit(EX_MemRead_i, EX_RTAddr_i, ID_RSAddr_i, ID_RTAddr_i);

    if (!rst_i) begin
      // Reset is decoded combinationally so the pipeline is held the moment reset asserts.
      state_d         = RUN;
      PCWrite_o       = 1'b0;
      IF_ID_Write_o   = 1'b0;
      IF_ID_Flush_o   = 1'b1;
      ID_EX_Write_o   = 1'b0;
      ID_EX_Bubble_o  = 1'b1;
      EX_MEM_Write_o  = 1'b0;
      MEM_WB_Bubble_o = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            // Freeze starts in the request cycle itself, not one cycle later.
            state_d         = MEM_WAIT;
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Write_o  = 1'b0;
            MEM_WB_Bubble_o = 1'b1;
          end else if (load_use) begin
            // Branch is ignored here: its operands are stale until the load lands.
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
          end else if (Branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!MEM_ack_i) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Write_o  = 1'b0;
            MEM_WB_Bubble_o = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == RUN) && (state_d == MEM_WAIT)) begin
        wait_cnt_q <= '0;
      end else if (state_q == MEM_WAIT) begin
        if (wait_cnt_q != WAIT_W'(TIMEOUT_CYC)) begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
        // Flag only; the controller keeps waiting for the ack.
        if (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err_timeout_o = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!PCWrite_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IF_ID_Flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule
